wb_lsu_master: RTL
==================

Name: wb_lsu_master

Overview:
Wishbone classic initiator that turns a simple valid/ready load/store request into one single-beat Wishbone cycle toward a 1-cycle-ack RAM responder.
- Returns the registered, size-formatted read data (or an error flag) on a valid/ready response port.
- Sits between the core's load/store unit (or fetch unit) and the iwb/dwb bus ports.
- Bus convention: byte address driven as-is; data LSB-justified (byte at addr on bits 7:0); little-endian lanes.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed 32; sel is DW/8 = 4 bits).
- TIMEOUT, 16, cycles in BUS without ack before an error response; 0 disables the timeout.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, LSB-justified.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  sign-extend load result.
- resp_valid  out  1  response present, held until resp_ready.
- resp_ready  in  1  response consumed.
- resp_rdata  out  DW  formatted load data; 0 for stores and errors.
- resp_err  out  1  timeout or illegal request.
- wb_addr  out  AW  Wishbone address.
- wb_wdata  out  DW  Wishbone write data.
- wb_sel  out  4  byte lane selects.
- wb_we  out  1  write enable.
- wb_cyc  out  1  cycle valid.
- wb_stb  out  1  strobe.
- wb_rdata  in  DW  read data from responder.
- wb_ack  in  1  responder acknowledge.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; wb_cyc=wb_stb=wb_we=0; wb_sel=0; wb_addr=wb_wdata=0; resp_valid=0; resp_rdata=0; resp_err=0; timeout counter=0. Reset during BUS or RESP aborts the cycle: cyc/stb are low after that edge, and the pending response is dropped.
- All Wishbone outputs are registered.
- States:
  - IDLE: req_ready=1. On accept with req_size≠3, latch the bus outputs and go to BUS. wb_sel = 0001 / 0011 / 1111 for size 0 / 1 / 2. wb_wdata = req_wdata masked to the size. cyc=stb=1 from the next cycle.
  - IDLE, req_size=3: no bus cycle; go to RESP with err=1.
  - BUS: req_ready=0. cyc and stb are held stable until ack.
    - On wb_ack=1: deassert cyc/stb at the next edge (single beat; the responder sees stb low, so there is no double ack). Capture formatted data: byte/half zero- or sign-extended per the latched signed bit, bit 7/15 is the sign source; word passes through. Stores capture 0. Go to RESP with err=0.
    - Timeout: counter increments each BUS cycle without ack. When counter == TIMEOUT−1 and no ack: drop cyc/stb, go to RESP with err=1, rdata=0. Ack in that same cycle wins (normal response).
  - RESP: resp_valid=1 and resp_rdata/resp_err stable until resp_ready. On resp_ready go to IDLE.
- Minimum turnaround is one transaction per 4 cycles (accept, BUS, ack, RESP) against a 1-cycle responder.
- Latency: accept edge t → cyc/stb high at t+1 → ack sampled at t+2 → resp_valid at t+3, with a 1-cycle-ack responder.
- wb_ack in IDLE or RESP is stale and ignored.
- Address wrap: wb_addr is the latched req_addr with no increment; no wrap logic.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half request with addr[0]≠0, or a word request with addr[1:0]≠0, gets no bus cycle and goes IDLE→RESP with resp_err=1, rdata=0.
- Undefined: misaligned accesses go to the bus unchanged (byte-addressed LSB-justified responder).

Decomposition:
- Package wb_pkg: size encoding constants (SZ_B=0, SZ_H=1, SZ_W=2), state enum (IDLE, BUS, RESP), the sel lookup function, and DW/8 constant.
- One sub-module, wb_load_fmt: combinational size mask and sign/zero extension, reused for store-data masking and load formatting.

Test Plan:
- Word store addr=0x100, wdata=0xDEADBEEF → wb_sel=1111, wb_we=1, one ack; resp_valid with rdata=0, err=0 at t+3.
- Then byte load signed addr=0x101 → wb_sel=0001; resp_rdata=0xFFFFFFBE. Same request unsigned → 0x000000BE.
- Half load unsigned addr=0x102 → resp_rdata=0x0000DEAD; signed → 0xFFFFDEAD.
- Responder never acks, TIMEOUT=8 → cyc high exactly 8 cycles, then resp_err=1, rdata=0; next request proceeds normally.
- resp_ready held 0 for 5 cycles after a load → resp_valid and rdata stable, req_ready=0 throughout, no new bus cycle; the 6th cycle's resp_ready returns to IDLE.
- reset=0 while in BUS → next cycle cyc=stb=0 and resp_valid=0; a late ack is ignored. req_size=3 → err=1 with no cyc. With MISALIGN_TRAP_EN, word at 0x102 → err=1, no cyc.

Source files
------------

// File: rtl/wb_lsu_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone load/store initiator:
//   - access size encodings (byte / half / word)
//   - FSM state enumeration
//   - byte-lane select lookup for an LSB-justified access
//   - bus data width and lane count
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int unsigned DW_FIXED = 32;
    localparam int unsigned SEL_W    = DW_FIXED / 8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Data is LSB-justified, so the lanes always start at lane 0 and only
    // the number of lanes depends on the size. Size 3 has no lanes.
    function automatic logic [SEL_W-1:0] sel_for_size(input logic [1:0] size);
        logic [SEL_W-1:0] sel;
        case (size)
            SZ_B:    sel = 4'b0001;
            SZ_H:    sel = 4'b0011;
            SZ_W:    sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_lsu_master_load_fmt.sv
// -----------------------------------------------------------------------------
// wb_load_fmt
// Purely combinational size mask with optional sign extension. Used both to
// mask store data before it goes on the bus and to format load data coming
// back from the responder.
// Ports:
//   data_in   in  32  LSB-justified raw data
//   size      in  2   0 = byte, 1 = half, 2 = word, 3 = illegal (yields 0)
//   is_signed in  1   replicate bit 7 / bit 15 into the upper bits
//   data_out  out 32  masked / extended data
// -----------------------------------------------------------------------------
module wb_load_fmt
    import wb_pkg::*;
(
    input  logic [DW_FIXED-1:0] data_in,
    input  logic [1:0]          size,
    input  logic                is_signed,
    output logic [DW_FIXED-1:0] data_out
);

    logic byte_sign;
    logic half_sign;

    assign byte_sign = is_signed & data_in[7];
    assign half_sign = is_signed & data_in[15];

    always_comb begin
        data_out = '0;
        case (size)
            SZ_B:    data_out = {{24{byte_sign}}, data_in[7:0]};
            SZ_H:    data_out = {{16{half_sign}}, data_in[15:0]};
            SZ_W:    data_out = data_in;
            default: data_out = '0;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// -----------------------------------------------------------------------------
// wb_lsu_master
// Wishbone classic initiator: turns one valid/ready load/store request into a
// single-beat Wishbone cycle and returns formatted read data (or an error) on
// a valid/ready response port. All Wishbone outputs come straight from flops.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests are answered with an error and
//               never reach the bus
//   undefined - misaligned requests go to the bus unchanged
//
// Parameters:
//   AW       address width
//   DW       data width (must be 32)
//   TIMEOUT  BUS cycles without ack before an error response, 0 = never
//
// Ports:
//   clock, reset (synchronous, active low)
//   req_*    request channel (valid/ready, addr, wdata, we, size, signed)
//   resp_*   response channel (valid/ready, rdata, err)
//   wb_*     Wishbone classic initiator signals
// -----------------------------------------------------------------------------
module wb_lsu_master
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,

    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,

    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_wdata,
    output logic [3:0]    wb_sel,
    output logic          wb_we,
    output logic          wb_cyc,
    output logic          wb_stb,
    input  logic [DW-1:0] wb_rdata,
    input  logic          wb_ack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic TMO_ON = (TIMEOUT > 0);

    state_t        state_q,      state_d;
    logic [AW-1:0] wb_addr_q,    wb_addr_d;
    logic [DW-1:0] wb_wdata_q,   wb_wdata_d;
    logic [3:0]    wb_sel_q,     wb_sel_d;
    logic          wb_we_q,      wb_we_d;
    logic          wb_cyc_q,     wb_cyc_d;
    logic [1:0]    size_q,       size_d;
    logic          signed_q,     signed_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          resp_err_q,   resp_err_d;
    logic [CW-1:0] tmo_cnt_q,    tmo_cnt_d;

    logic [DW-1:0] store_masked;
    logic [DW-1:0] load_formatted;
    logic          misaligned;
    logic          illegal_req;
    logic          timeout_hit;

    // Store data is masked with the request's own size; signedness is
    // irrelevant for stores.
    wb_load_fmt u_store_mask (
        .data_in   (req_wdata),
        .size      (req_size),
        .is_signed (1'b0),
        .data_out  (store_masked)
    );

    // Load data uses the size/sign latched at accept time.
    wb_load_fmt u_load_fmt (
        .data_in   (wb_rdata),
        .size      (size_q),
        .is_signed (signed_q),
        .data_out  (load_formatted)
    );

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign illegal_req = (req_size == 2'd3) || misaligned;
    assign timeout_hit = TMO_ON && (tmo_cnt_q == TMO_LAST);

    // Next-state logic. An ack always beats a timeout in the same cycle, and
    // acks seen outside BUS are stale leftovers that are ignored.
    always_comb begin
        state_d      = state_q;
        wb_addr_d    = wb_addr_q;
        wb_wdata_d   = wb_wdata_q;
        wb_sel_d     = wb_sel_q;
        wb_we_d      = wb_we_q;
        wb_cyc_d     = wb_cyc_q;
        size_d       = size_q;
        signed_d     = signed_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal_req) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d    = BUS;
                        wb_addr_d  = req_addr;
                        wb_wdata_d = store_masked;
                        wb_sel_d   = sel_for_size(req_size);
                        wb_we_d    = req_we;
                        wb_cyc_d   = 1'b1;
                        size_d     = req_size;
                        signed_d   = req_signed;
                        tmo_cnt_d  = '0;
                    end
                end
            end
            BUS: begin
                if (wb_ack) begin
                    state_d      = RESP;
                    wb_cyc_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = wb_we_q ? '0 : load_formatted;
                end else if (timeout_hit) begin
                    state_d      = RESP;
                    wb_cyc_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                wb_cyc_d     = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Single state register; reset drops any cycle or pending response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            wb_addr_q    <= '0;
            wb_wdata_q   <= '0;
            wb_sel_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_cyc_q     <= 1'b0;
            size_q       <= SZ_B;
            signed_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wb_addr_q    <= wb_addr_d;
            wb_wdata_q   <= wb_wdata_d;
            wb_sel_q     <= wb_sel_d;
            wb_we_q      <= wb_we_d;
            wb_cyc_q     <= wb_cyc_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign wb_addr    = wb_addr_q;
    assign wb_wdata   = wb_wdata_q;
    assign wb_sel     = wb_sel_q;
    assign wb_we      = wb_we_q;
    assign wb_cyc     = wb_cyc_q;
    assign wb_stb     = wb_cyc_q;

endmodule
